// File: rtl/bus_responder.sv
// Memory-mapped CPU responder: zero-wait RAM, debug and cycle registers, and a byte TX FIFO
// with status and a sticky fault flag for writes to unmapped addresses.
module bus_responder #(
  parameter int MEM_WORDS  = 1024,
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] in_address_bus,
  input  logic        in_mem_write_en,
  input  logic [31:0] in_mem_write_data,
  output logic [31:0] out_mem_read_data,
  output logic [7:0]  out_tx_data,
  output logic        out_tx_valid,
  input  logic        in_tx_ready,
  output logic [31:0] out_debug_port,
  output logic        out_fault
);

  localparam int AW = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  localparam logic [31:0] DBG_ADDR    = 32'hFFFF_0000;
  localparam logic [31:0] CYCLE_ADDR  = 32'hFFFF_0004;
  localparam logic [31:0] TXDATA_ADDR = 32'hFFFF_0008;
  localparam logic [31:0] STATUS_ADDR = 32'hFFFF_000C;

  logic [31:0]   mem [MEM_WORDS];
  logic [7:0]    fifo_mem [FIFO_DEPTH];
  logic [31:0]   dbg_q;
  logic [31:0]   cycle_q;
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [CW-1:0] count;
  logic          overflow;
  logic          fault_q;

  logic          sel_ram, sel_dbg, sel_cycle, sel_tx, sel_status, sel_unmapped;
  logic [AW-1:0] word_idx;
  logic          fifo_empty, fifo_full;
  logic          push_req, push, pop, drop;
  logic [31:0]   status_word;

  assign word_idx     = in_address_bus[AW+1:2];
  assign sel_ram      = (in_address_bus[31:AW+2] == '0);
  assign sel_dbg      = (in_address_bus == DBG_ADDR);
  assign sel_cycle    = (in_address_bus == CYCLE_ADDR);
  assign sel_tx       = (in_address_bus == TXDATA_ADDR);
  assign sel_status   = (in_address_bus == STATUS_ADDR);
  assign sel_unmapped = !(sel_ram || sel_dbg || sel_cycle || sel_tx || sel_status);

  assign fifo_empty = (count == '0);
  assign fifo_full  = (count == CW'(FIFO_DEPTH));
  assign pop        = !fifo_empty && in_tx_ready;
  // A full FIFO still takes a push when the head leaves in the same cycle.
  assign push_req   = in_mem_write_en && sel_tx;
  assign push       = push_req && (!fifo_full || pop);
  assign drop       = push_req && fifo_full && !pop;

  assign status_word = {15'b0, overflow, 6'b0, fifo_full, fifo_empty, 4'b0, 4'(count)};

  always_comb begin
    out_mem_read_data = 32'h0;
    if (sel_ram)         out_mem_read_data = mem[word_idx];
    else if (sel_dbg)    out_mem_read_data = dbg_q;
    else if (sel_cycle)  out_mem_read_data = cycle_q;
    else if (sel_status) out_mem_read_data = status_word;
  end

  // RAM and FIFO storage carry no reset; only pointers and flags are cleared.
  always_ff @(posedge clk) begin
    if (!reset && in_mem_write_en && sel_ram)
      mem[word_idx] <= in_mem_write_data;
  end

  always_ff @(posedge clk) begin
    if (!reset && push)
      fifo_mem[wr_ptr] <= in_mem_write_data[7:0];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      dbg_q    <= 32'h0;
      cycle_q  <= 32'h0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
      fault_q  <= 1'b0;
    end else begin
      cycle_q <= (in_mem_write_en && sel_cycle) ? in_mem_write_data : cycle_q + 32'd1;
      if (in_mem_write_en && sel_dbg)
        dbg_q <= in_mem_write_data;
      if (push)
        wr_ptr <= wr_ptr + PW'(1);
      if (pop)
        rd_ptr <= rd_ptr + PW'(1);
      if (push && !pop)
        count <= count + CW'(1);
      else if (pop && !push)
        count <= count - CW'(1);
      if (drop)
        overflow <= 1'b1;
      else if (in_mem_write_en && sel_status && in_mem_write_data[16])
        overflow <= 1'b0;
      if (in_mem_write_en && sel_unmapped)
        fault_q <= 1'b1;
    end
  end

  assign out_tx_valid   = !fifo_empty;
  assign out_tx_data    = fifo_empty ? 8'h00 : fifo_mem[rd_ptr];
  assign out_debug_port = dbg_q;
  assign out_fault      = fault_q;

endmodule

// File: tb/tb_bus_responder.sv
// Bench for bus_responder: directed scenarios with literal expectations plus random traffic
// checked every cycle against a queue/array model of the address map.
module tb_bus_responder;

  localparam int MEM_WORDS  = 1024;
  localparam int FIFO_DEPTH = 4;
  localparam logic [31:0] A_DBG = 32'hFFFF_0000;
  localparam logic [31:0] A_CYC = 32'hFFFF_0004;
  localparam logic [31:0] A_TX  = 32'hFFFF_0008;
  localparam logic [31:0] A_ST  = 32'hFFFF_000C;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] address_bus = A_CYC;
  logic        mem_write_en = 1'b0;
  logic [31:0] mem_write_data = 32'h0;
  logic [31:0] mem_read_data;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready = 1'b0;
  logic [31:0] debug_port;
  logic        fault;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  bus_responder #(.MEM_WORDS(MEM_WORDS), .FIFO_DEPTH(FIFO_DEPTH)) dut (
    .clk              (clk),
    .reset            (reset),
    .in_address_bus   (address_bus),
    .in_mem_write_en  (mem_write_en),
    .in_mem_write_data(mem_write_data),
    .out_mem_read_data(mem_read_data),
    .out_tx_data      (tx_data),
    .out_tx_valid     (tx_valid),
    .in_tx_ready      (tx_ready),
    .out_debug_port   (debug_port),
    .out_fault        (fault)
  );

  // Reference model: register values, a byte queue for the FIFO, and a RAM array with
  // a per-word flag so never-written RAM words are not compared.
  bit [31:0]    m_ram [MEM_WORDS];
  bit           m_known [MEM_WORDS];
  bit [31:0]    m_dbg, m_cycle;
  bit [7:0]     m_q [$];
  bit           m_ov, m_fault;
  bit           m_live = 1'b0;

  function automatic bit is_ram(input logic [31:0] a);
    return a < 32'(4 * MEM_WORDS);
  endfunction

  function automatic bit [31:0] model_status();
    bit [31:0] s;
    s = 32'(m_q.size());
    if (m_q.size() == 0) s = s + 32'h100;
    if (m_q.size() == FIFO_DEPTH) s = s + 32'h200;
    if (m_ov) s = s + 32'h1_0000;
    return s;
  endfunction

  function automatic bit [31:0] model_read(input logic [31:0] a);
    if (is_ram(a)) return m_ram[int'(a >> 2)];
    if (a == A_DBG) return m_dbg;
    if (a == A_CYC) return m_cycle;
    if (a == A_ST)  return model_status();
    return 32'h0;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, actual, expected, $time);
    end
  endtask

  always @(posedge clk) begin
    bit popped;
    bit was_full;
    if (reset) begin
      m_dbg = 0; m_cycle = 0; m_q.delete(); m_ov = 0; m_fault = 0; m_live = 1'b1;
    end else if (m_live) begin
      popped   = (m_q.size() > 0) && tx_ready;
      was_full = (m_q.size() == FIFO_DEPTH);
      m_cycle  = m_cycle + 1;
      if (popped) void'(m_q.pop_front());
      if (mem_write_en) begin
        if (is_ram(address_bus)) begin
          m_ram[int'(address_bus >> 2)]   = mem_write_data;
          m_known[int'(address_bus >> 2)] = 1'b1;
        end else if (address_bus == A_DBG) m_dbg = mem_write_data;
        else if (address_bus == A_CYC) m_cycle = mem_write_data;
        else if (address_bus == A_TX) begin
          if (!was_full || popped) m_q.push_back(mem_write_data[7:0]);
          else m_ov = 1'b1;
        end else if (address_bus == A_ST) begin
          if (mem_write_data[16]) m_ov = 1'b0;
        end else m_fault = 1'b1;
      end
    end
  end

  // Every cycle, shortly after inputs change, outputs must match the model.
  always @(negedge clk) begin
    #2;
    if (m_live) begin
      if (!is_ram(address_bus) || m_known[int'(address_bus >> 2)])
        checkOutput("read_data", mem_read_data, model_read(address_bus));
      checkOutput("tx_valid", 32'(tx_valid), 32'(m_q.size() > 0));
      checkOutput("tx_data", 32'(tx_data), (m_q.size() > 0) ? 32'(m_q[0]) : 32'h0);
      checkOutput("debug_port", debug_port, m_dbg);
      checkOutput("fault", 32'(fault), 32'(m_fault));
    end
  end

  task automatic applyStimulus(input logic rst, input logic [31:0] a, input logic w,
                               input logic [31:0] d, input logic rdy);
    @(negedge clk);
    reset = rst; address_bus = a; mem_write_en = w; mem_write_data = d; tx_ready = rdy;
    #3;
  endtask

  initial begin
    logic [7:0]  exp35 [4];
    logic [31:0] a;
    logic [31:0] d;
    logic        w;
    int          cat;
    exp35 = '{8'h62, 8'h63, 8'h64, 8'h55};

    applyStimulus(1, A_CYC, 0, 0, 0);
    applyStimulus(1, A_DBG, 1, 32'hDEAD_BEEF, 0);
    applyStimulus(0, A_CYC, 0, 0, 0);
    checkOutput("cycle_after_reset_0", mem_read_data, 32'h0);
    checkOutput("dbg_after_reset", debug_port, 32'h0);
    checkOutput("valid_after_reset", 32'(tx_valid), 32'h0);
    checkOutput("txdata_after_reset", 32'(tx_data), 32'h0);
    checkOutput("fault_after_reset", 32'(fault), 32'h0);
    applyStimulus(0, A_CYC, 0, 0, 0);
    checkOutput("cycle_after_reset_1", mem_read_data, 32'h1);
    applyStimulus(0, A_ST, 0, 0, 0);
    checkOutput("status_after_reset", mem_read_data, 32'h0000_0100);

    applyStimulus(0, 32'h10, 1, 32'h1111_2222, 0);
    applyStimulus(0, 32'h10, 1, 32'hCAFE_F00D, 0);
    checkOutput("ram_same_cycle_old", mem_read_data, 32'h1111_2222);
    applyStimulus(0, 32'h10, 0, 0, 0);
    checkOutput("ram_next_cycle_new", mem_read_data, 32'hCAFE_F00D);
    applyStimulus(0, 32'h13, 0, 0, 0);
    checkOutput("ram_byte_offset", mem_read_data, 32'hCAFE_F00D);

    for (int i = 0; i < 5; i++) begin
      applyStimulus(0, A_TX, 1, 32'h41 + 32'(i), 0);
      if (i == 0) checkOutput("txdata_reads_zero", mem_read_data, 32'h0);
    end
    applyStimulus(0, A_ST, 0, 0, 0);
    checkOutput("status_full_overflow", mem_read_data, 32'h0001_0204);
    checkOutput("head_after_fill", 32'(tx_data), 32'h41);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(0, A_CYC, 0, 0, 1);
      checkOutput("drain_valid", 32'(tx_valid), 32'h1);
      checkOutput("drain_byte", 32'(tx_data), 32'h41 + 32'(i));
    end
    applyStimulus(0, A_CYC, 0, 0, 1);
    checkOutput("drained_valid", 32'(tx_valid), 32'h0);
    checkOutput("drained_data", 32'(tx_data), 32'h0);
    applyStimulus(0, A_ST, 1, 32'h0001_0000, 0);
    applyStimulus(0, A_ST, 0, 0, 0);
    checkOutput("overflow_cleared", mem_read_data, 32'h0000_0100);

    for (int i = 0; i < 4; i++) applyStimulus(0, A_TX, 1, 32'h61 + 32'(i), 0);
    applyStimulus(0, A_TX, 1, 32'h55, 1);
    checkOutput("full_pushpop_head", 32'(tx_data), 32'h61);
    applyStimulus(0, A_ST, 0, 0, 0);
    checkOutput("full_pushpop_status", mem_read_data, 32'h0000_0204);
    for (int k = 0; k < 4; k++) begin
      applyStimulus(0, A_CYC, 0, 0, 1);
      checkOutput("full_pushpop_order", 32'(tx_data), 32'(exp35[k]));
    end
    applyStimulus(0, A_CYC, 0, 0, 0);
    checkOutput("full_pushpop_empty", 32'(tx_valid), 32'h0);

    applyStimulus(0, A_CYC, 1, 32'hFFFF_FFFE, 0);
    applyStimulus(0, A_CYC, 0, 0, 0);
    checkOutput("cycle_load", mem_read_data, 32'hFFFF_FFFE);
    applyStimulus(0, A_CYC, 0, 0, 0);
    checkOutput("cycle_max", mem_read_data, 32'hFFFF_FFFF);
    applyStimulus(0, A_CYC, 0, 0, 0);
    checkOutput("cycle_wrap", mem_read_data, 32'h0);

    applyStimulus(0, 32'h8000_0000, 1, 32'h1, 0);
    checkOutput("fault_not_yet", 32'(fault), 32'h0);
    applyStimulus(0, 32'h8000_0000, 0, 0, 0);
    checkOutput("fault_set", 32'(fault), 32'h1);
    checkOutput("unmapped_read", mem_read_data, 32'h0);
    applyStimulus(0, A_CYC, 0, 0, 0);
    checkOutput("fault_held", 32'(fault), 32'h1);
    applyStimulus(1, A_CYC, 0, 0, 0);
    applyStimulus(0, A_CYC, 0, 0, 0);
    checkOutput("fault_reset", 32'(fault), 32'h0);

    for (int i = 0; i < 3; i++) applyStimulus(0, A_TX, 1, 32'h71 + 32'(i), 0);
    applyStimulus(0, A_DBG, 1, 32'h1234, 0);
    applyStimulus(0, 32'h20, 1, 32'hA5A5_5A5A, 0);
    checkOutput("dbg_port_loaded", debug_port, 32'h1234);
    applyStimulus(0, A_ST, 0, 0, 0);
    checkOutput("status_three", mem_read_data, 32'h0000_0003);
    applyStimulus(1, A_DBG, 1, 32'h9999, 1);
    applyStimulus(0, 32'h20, 0, 0, 0);
    checkOutput("midreset_valid", 32'(tx_valid), 32'h0);
    checkOutput("midreset_data", 32'(tx_data), 32'h0);
    checkOutput("midreset_dbg", debug_port, 32'h0);
    checkOutput("midreset_ram", mem_read_data, 32'hA5A5_5A5A);
    applyStimulus(0, A_ST, 0, 0, 0);
    checkOutput("midreset_status", mem_read_data, 32'h0000_0100);

    for (int n = 0; n < 3000; n++) begin
      cat = $urandom_range(0, 9);
      d = $urandom;
      w = 1'($urandom_range(0, 1));
      case (cat)
        0, 1:    a = 32'($urandom_range(0, 63)) * 4 + 32'($urandom_range(0, 3));
        2, 3:    a = 32'($urandom_range(0, MEM_WORDS - 1)) * 4 + 32'($urandom_range(0, 3));
        4:       a = A_DBG;
        5:       a = A_CYC;
        6, 7:    a = A_TX;
        8:       a = A_ST;
        default: begin
          case ($urandom_range(0, 2))
            0:       a = 32'h8000_0000 | ($urandom & 32'h7FFF_FFFC);
            1:       a = 32'h0000_1000 + 32'($urandom_range(0, 255)) * 4;
            default: a = 32'hFFFF_0010 + 32'($urandom_range(0, 15)) * 4;
          endcase
          w = ($urandom_range(0, 7) == 0);
        end
      endcase
      applyStimulus(($urandom_range(0, 99) == 0), a, w, d, ($urandom_range(0, 3) == 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
